// File: rtl/vga_pkg.sv
// Shared VGA timing constants, polarity values and helpers
// for the parametrised timing generator.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam bit POL_LOW  = 1'b0;
    localparam bit POL_HIGH = 1'b1;

    localparam int VGA_MAX_TOTAL   = 1024;
    localparam int VGA_MAX_LATENCY = 15;
    localparam int VGA_COORD_W     = 10;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
        logic ls;
    } vga_ctl_t;

    function automatic int vga_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_delay_pipe.sv
// Width/depth parametrised shift register with async clear;
// a depth of zero is a plain passthrough.
module vga_delay_pipe #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign q = d;
    end else begin : g_shift
        logic [W-1:0] stage [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage[i] <= '0;
                end
            end else begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: H/V counters, pixel request with programmable
// return latency, and latency-aligned sync/de/strobe outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE     = VGA_H_ACTIVE,
    parameter int H_FP         = VGA_H_FP,
    parameter int H_SYNC       = VGA_H_SYNC,
    parameter int H_BP         = VGA_H_BP,
    parameter int V_ACTIVE     = VGA_V_ACTIVE,
    parameter int V_FP         = VGA_V_FP,
    parameter int V_SYNC       = VGA_V_SYNC,
    parameter int V_BP         = VGA_V_BP,
    parameter bit HS_POL       = POL_LOW,
    parameter bit VS_POL       = POL_LOW,
    parameter int DATA_LATENCY = 1,
    parameter int COLOR_W      = 24,
    parameter int FCNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [COLOR_W-1:0] data,
    output logic               req,
    output logic [9:0]         x_pix,
    output logic [9:0]         y_pix,
    output logic               hs,
    output logic               vs,
    output logic               de,
    output logic [COLOR_W-1:0] color_rgb,
    output logic               frame_start,
    output logic               line_start,
    output logic [FCNT_W-1:0]  frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = vga_clog2(H_TOTAL);
    localparam int VW      = vga_clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_ON  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_OFF = HW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_ON  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_OFF = VW'(V_ACTIVE + V_FP + V_SYNC);

    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
        $error("vga_timing_gen: porch and sync widths must be nonzero");
    end

    if (H_TOTAL > VGA_MAX_TOTAL || V_TOTAL > VGA_MAX_TOTAL) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end

    if (DATA_LATENCY < 0 || DATA_LATENCY > VGA_MAX_LATENCY) begin : g_bad_lat
        $error("vga_timing_gen: DATA_LATENCY must be within 0..15");
    end

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_last;
    logic          v_last;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (en && h_last && v_last) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign req   = en && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    assign x_pix = req ? 10'(h_cnt) : '0;
    assign y_pix = req ? 10'(v_cnt) : '0;

    vga_ctl_t ctl_raw;
    vga_ctl_t ctl_del;

    // Syncs are gated by en so a disable reaches the outputs in LAT+1.
    always_comb begin
        ctl_raw    = '0;
        ctl_raw.de = req;
        ctl_raw.hs = en && (h_cnt >= H_SYNC_ON) && (h_cnt < H_SYNC_OFF);
        ctl_raw.vs = en && (v_cnt >= V_SYNC_ON) && (v_cnt < V_SYNC_OFF);
        ctl_raw.fs = req && (h_cnt == '0) && (v_cnt == '0);
        ctl_raw.ls = req && (h_cnt == '0);
    end

    vga_delay_pipe #(
        .W     ($bits(vga_ctl_t)),
        .DEPTH (DATA_LATENCY)
    ) u_ctl_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ctl_raw),
        .q     (ctl_del)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            color_rgb   <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            hs          <= ctl_del.hs ? HS_POL : ~HS_POL;
            vs          <= ctl_del.vs ? VS_POL : ~VS_POL;
            de          <= ctl_del.de;
            color_rgb   <= ctl_del.de ? data : '0;
            frame_start <= ctl_del.fs;
            line_start  <= ctl_del.ls;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen: four instances with different
// latencies/counter widths checked every cycle against a frame-position model.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int NI = 4;

    function automatic int lat_of(input int i);
        case (i)
            0: return 2;
            1: return 0;
            2: return 5;
            default: return 2;
        endcase
    endfunction

    function automatic int fw_of(input int i);
        return (i == 3) ? 2 : 16;
    endfunction

    logic clk;
    logic rst_n;
    logic en;

    logic [NI-1:0] req_w, hs_w, vs_w, de_w, fs_w, ls_w;
    logic [9:0]    x_w [NI];
    logic [9:0]    y_w [NI];
    logic [23:0]   col_w [NI];
    logic [15:0]   fc_w [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int L  = lat_of(gi);
        localparam int FW = fw_of(gi);

        logic          req, hs, vs, de, fs, ls;
        logic [9:0]    x, y;
        logic [23:0]   color, data, src_now;
        logic [FW-1:0] fc;
        logic [23:0]   src_hist [16];

        assign src_now = {4'hA, x, y};

        always @(posedge clk) begin
            src_hist[0] <= src_now;
            for (int k = 1; k < 16; k++) src_hist[k] <= src_hist[k-1];
        end

        if (L == 0) begin : g_comb
            assign data = src_now;
        end else begin : g_seq
            assign data = src_hist[L-1];
        end

        vga_timing_gen #(
            .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
            .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
            .HS_POL(1'b0), .VS_POL(1'b0),
            .DATA_LATENCY(L), .COLOR_W(24), .FCNT_W(FW)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .en(en), .data(data),
            .req(req), .x_pix(x), .y_pix(y),
            .hs(hs), .vs(vs), .de(de), .color_rgb(color),
            .frame_start(fs), .line_start(ls), .frame_cnt(fc)
        );

        assign req_w[gi] = req;
        assign hs_w[gi]  = hs;
        assign vs_w[gi]  = vs;
        assign de_w[gi]  = de;
        assign fs_w[gi]  = fs;
        assign ls_w[gi]  = ls;
        assign x_w[gi]   = x;
        assign y_w[gi]   = y;
        assign col_w[gi] = color;
        assign fc_w[gi]  = 16'(fc);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: linear tick count within the frame, history of past ticks.
    typedef struct {
        bit v;
        int c;
    } ent_t;

    ent_t hist [8];
    int   c_m;
    int   fc_m [NI];

    task automatic check_inst(input int i);
        int  l, x0, y0, xe, ye;
        bit  req_e, de_e, hs_e, vs_e;
        ent_t e;
        logic [23:0] col_e;
        l     = lat_of(i);
        x0    = c_m % HT;
        y0    = c_m / HT;
        req_e = en && x0 < HA && y0 < VA;
        chk($sformatf("req%0d", i), req_w[i], req_e);
        chk($sformatf("x%0d", i), x_w[i], req_e ? x0 : 0);
        chk($sformatf("y%0d", i), y_w[i], req_e ? y0 : 0);
        e     = hist[l+1];
        xe    = e.c % HT;
        ye    = e.c / HT;
        de_e  = e.v && xe < HA && ye < VA;
        hs_e  = e.v && xe >= HA + HF && xe < HA + HF + HS;
        vs_e  = e.v && ye >= VA + VF && ye < VA + VF + VS;
        col_e = de_e ? {4'hA, 10'(xe), 10'(ye)} : 24'h0;
        chk($sformatf("de%0d", i), de_w[i], de_e);
        chk($sformatf("hs%0d", i), hs_w[i], !hs_e);
        chk($sformatf("vs%0d", i), vs_w[i], !vs_e);
        chk($sformatf("color%0d", i), col_w[i], col_e);
        chk($sformatf("fstart%0d", i), fs_w[i], de_e && xe == 0 && ye == 0);
        chk($sformatf("lstart%0d", i), ls_w[i], de_e && xe == 0);
        chk($sformatf("fcnt%0d", i), fc_w[i], fc_m[i]);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            c_m = 0;
            for (int i = 0; i < NI; i++) fc_m[i] = 0;
            for (int k = 0; k < 8; k++) hist[k] = '{0, 0};
        end
        hist[0] = '{rst_n && en, c_m};
        for (int i = 0; i < NI; i++) check_inst(i);
        if (rst_n) begin
            if (en && c_m == FT - 1) begin
                for (int i = 0; i < NI; i++)
                    fc_m[i] = (fc_m[i] + 1) % (1 << fw_of(i));
            end
            c_m = en ? (c_m + 1) % FT : 0;
        end
        for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    end

    int cur;

    task automatic goto(input int k);
        while (cur < k) begin
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic pin_start();
        chk("pin_req0", req_w[0], 1);
        chk("pin_x0", x_w[0], 0);
        chk("pin_y0", y_w[0], 0);
        goto(1);
        chk("pin_l0_de", de_w[1], 1);
        chk("pin_l0_fs", fs_w[1], 1);
        chk("pin_l2_de_early", de_w[0], 0);
        goto(3);
        chk("pin_de", de_w[0], 1);
        chk("pin_fs", fs_w[0], 1);
        chk("pin_ls", ls_w[0], 1);
        chk("pin_col00", col_w[0], 24'hA00000);
        goto(4);
        chk("pin_fs_once", fs_w[0], 0);
        goto(6);
        chk("pin_l5_de", de_w[2], 1);
        chk("pin_l5_col", col_w[2], 24'hA00000);
    endtask

    int rst_hold;

    initial begin
        rst_n = 1'b1;
        en    = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        cur = 0;
        pin_start();

        goto(10); chk("pin_col70", col_w[0], 24'hA01C00);
        goto(11); chk("pin_de_end", de_w[0], 0);
        goto(12); chk("pin_hs_pre", hs_w[0], 1);
        goto(13); chk("pin_hs_on", hs_w[0], 0);
        goto(15); chk("pin_hs_last", hs_w[0], 0);
        goto(16); chk("pin_hs_off", hs_w[0], 1);
        goto(19); chk("pin_ls_l1", ls_w[0], 1);
        chk("pin_col01", col_w[0], 24'hA00001);
        goto(20); chk("pin_ls_once", ls_w[0], 0);
        goto(82); chk("pin_vs_pre", vs_w[0], 1);
        goto(83); chk("pin_vs_on", vs_w[0], 0);
        goto(114); chk("pin_vs_last", vs_w[0], 0);
        goto(115); chk("pin_vs_off", vs_w[0], 1);
        goto(127); chk("pin_fc_0", fc_w[0], 0);
        goto(128); chk("pin_fc_1", fc_w[0], 1);
        goto(131); chk("pin_fs_f2", fs_w[0], 1);

        goto(147);
        @(posedge clk); #1 en = 1'b0;
        @(negedge clk); cur = 148;
        chk("pin_en_req", req_w[0], 0);
        chk("pin_en_x", x_w[0], 0);
        goto(150); chk("pin_en_de_tail", de_w[0], 1);
        goto(151); chk("pin_en_de_off", de_w[0], 0);
        goto(159);
        @(posedge clk); #1 en = 1'b1;
        @(negedge clk); cur = 160;
        chk("pin_re_req", req_w[0], 1);
        chk("pin_re_y", y_w[0], 0);
        goto(163); chk("pin_re_fs", fs_w[0], 1);

        goto(196);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("arst_de%0d", i), de_w[i], 0);
            chk($sformatf("arst_hs%0d", i), hs_w[i], 1);
            chk($sformatf("arst_vs%0d", i), vs_w[i], 1);
            chk($sformatf("arst_col%0d", i), col_w[i], 0);
            chk($sformatf("arst_fc%0d", i), fc_w[i], 0);
            chk($sformatf("arst_x%0d", i), x_w[i], 0);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        cur = 0;
        pin_start();

        goto(128); chk("fw2_a", fc_w[3], 1);
        goto(256); chk("fw2_b", fc_w[3], 2);
        goto(384); chk("fw2_c", fc_w[3], 3);
        goto(512); chk("fw2_d", fc_w[3], 0);
        goto(640); chk("fw2_e", fc_w[3], 1);
        chk("fw16_5", fc_w[0], 5);

        rst_hold = 0;
        for (int n = 0; n < 1500; n++) begin
            @(posedge clk); #1;
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end else if ($urandom_range(299) == 0) begin
                rst_n    = 1'b0;
                rst_hold = $urandom_range(3, 1);
            end
            if (en ? ($urandom_range(199) == 0) : ($urandom_range(5) == 0))
                en = ~en;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
